// File: rtl/cap_pkg.sv
// Shared types and constants for the scope capture/dump controller.
package cap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREFILL,
    ST_ARMED,
    ST_POST,
    ST_DONE,
    ST_DUMP
  } cap_state_t;

  localparam logic [1:0] TRIG_OFF  = 2'b00;
  localparam logic [1:0] TRIG_NORM = 2'b01;
  localparam logic [1:0] TRIG_AUTO = 2'b10;

  localparam int RAM_LAT = 1;

  function automatic logic is_capturing(cap_state_t s);
    return (s == ST_PREFILL) || (s == ST_ARMED) || (s == ST_POST);
  endfunction

endpackage

// File: rtl/cap_decimator.sv
// Sample-strobe decimator: passes one of every 2**dec_pwr strobes as a keep pulse.
module cap_decimator #(
  parameter int DEC_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             smpl_en,
  input  logic [DEC_W-1:0] dec_pwr,
  output logic             keep
);

  localparam int CNT_W = 2**DEC_W;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] limit;

  assign limit = (CNT_W'(1) << dec_pwr) - CNT_W'(1);
  assign keep  = en & smpl_en & (cnt == limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en && smpl_en)
      cnt <= keep ? '0 : cnt + CNT_W'(1);
  end

endmodule

// File: rtl/capture_ctrl.sv
// Capture/dump controller: circular trace capture with pre/post trigger, then oldest-first dump.
// Optional CAPTURE_AUTO_REARM_EN: re-enter PREFILL after a dump instead of waiting for cap_start.
module capture_ctrl
  import cap_pkg::*;
#(
  parameter  int ADDR_W = 9,
  parameter  int DEC_W  = 4,
  parameter  int NUM_CH = 3,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cap_start,
  input  logic              smpl_en,
  input  logic              trigger,
  input  logic [1:0]        trig_type,
  input  logic [ADDR_W-1:0] trig_pos,
  input  logic [DEC_W-1:0]  dec_pwr,
  input  logic              dump_start,
  input  logic [CH_W-1:0]   dump_ch,
  input  logic              dump_rdy,
  output logic              we,
  output logic              re,
  output logic [ADDR_W-1:0] addr,
  output logic [CH_W-1:0]   ch_sel,
  output logic              dump_vld,
  output logic              armed,
  output logic              capture_done,
  output logic              dump_finished,
  output logic [ADDR_W-1:0] trace_end
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_V = {1'b1, {ADDR_W{1'b0}}};

  cap_state_t          state, next_state;
  logic                keep, clr, trig_off, trig_hit;
  logic                pre_last, post_last, finish_now;
  logic [ADDR_W:0]     pre_cnt, post_cnt, rd_cnt, pre_thr, tp_ext;
  logic [ADDR_W-1:0]   vld_cnt;
  logic [RAM_LAT-1:0]  vld_sr;

  cap_decimator #(.DEC_W(DEC_W)) u_dec (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clr),
    .en      (is_capturing(state)),
    .smpl_en (smpl_en),
    .dec_pwr (dec_pwr),
    .keep    (keep)
  );

  // trig_pos is ADDR_W wide, so it can never exceed DEPTH-1 and needs no explicit clamp.
  assign tp_ext     = {1'b0, trig_pos};
  assign pre_thr    = DEPTH_V - tp_ext;
  assign trig_off   = (trig_type == TRIG_OFF);
  assign trig_hit   = ((trig_type == TRIG_NORM) && trigger) || ((trig_type & TRIG_AUTO) != 2'b00);
  assign pre_last   = we && ((pre_cnt + (ADDR_W+1)'(1)) == pre_thr);
  assign post_last  = we && ((post_cnt + (ADDR_W+1)'(1)) == tp_ext);
  assign finish_now = (state == ST_DUMP) && dump_vld && (vld_cnt == ADDR_W'(DEPTH-1));
  assign clr        = (next_state == ST_IDLE) || ((next_state == ST_PREFILL) && (state != ST_PREFILL));
  assign dump_vld   = vld_sr[RAM_LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= ST_IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (cap_start && !trig_off) next_state = ST_PREFILL;
      ST_PREFILL: if (trig_off) next_state = ST_IDLE;
                  else if (pre_last) next_state = ST_ARMED;
      ST_ARMED:   if (trig_off) next_state = ST_IDLE;
                  else if (trig_hit) next_state = (trig_pos == '0) ? ST_DONE : ST_POST;
      ST_POST:    if (trig_off) next_state = ST_IDLE;
                  else if (post_last) next_state = ST_DONE;
      ST_DONE:    if (dump_start) next_state = ST_DUMP;
      ST_DUMP:    if (finish_now) begin
`ifdef CAPTURE_AUTO_REARM_EN
                    next_state = trig_off ? ST_IDLE : ST_PREFILL;
`else
                    next_state = ST_IDLE;
`endif
                  end
      default:    next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    armed        = (state == ST_ARMED) || (state == ST_POST);
    capture_done = (state == ST_DONE) || (state == ST_DUMP);
    re           = (state == ST_DUMP) && dump_rdy && (rd_cnt != DEPTH_V);
  end

  // A kept strobe only becomes a write if the capture is still running next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we            <= 1'b0;
      dump_finished <= 1'b0;
      addr          <= '0;
      trace_end     <= '0;
      ch_sel        <= '0;
      pre_cnt       <= '0;
      post_cnt      <= '0;
      rd_cnt        <= '0;
      vld_cnt       <= '0;
      vld_sr        <= '0;
    end else begin
      we            <= keep && is_capturing(next_state);
      dump_finished <= finish_now;
      if (clr) begin
        addr      <= '0;
        trace_end <= '0;
        ch_sel    <= '0;
        pre_cnt   <= '0;
        post_cnt  <= '0;
        rd_cnt    <= '0;
        vld_cnt   <= '0;
        vld_sr    <= '0;
      end else begin
        vld_sr <= RAM_LAT'({vld_sr, re});
        if (we) begin
          addr      <= addr + ADDR_W'(1);
          trace_end <= addr;
          if (state == ST_PREFILL) pre_cnt  <= pre_cnt + (ADDR_W+1)'(1);
          if (state == ST_POST)    post_cnt <= post_cnt + (ADDR_W+1)'(1);
        end
        if (state == ST_ARMED) post_cnt <= '0;
        // Oldest sample sits just after the last write.
        if ((state == ST_DONE) && dump_start) begin
          addr    <= trace_end + ADDR_W'(1);
          ch_sel  <= dump_ch;
          rd_cnt  <= '0;
          vld_cnt <= '0;
        end
        if (re) begin
          addr   <= addr + ADDR_W'(1);
          rd_cnt <= rd_cnt + (ADDR_W+1)'(1);
        end
        if (dump_vld) vld_cnt <= vld_cnt + ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed self-checking bench for capture_ctrl with hand-computed expected values.
module tb_capture_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cap_start = 1'b0;
  logic       smpl_en = 1'b0;
  logic       trigger = 1'b0;
  logic [1:0] trig_type = 2'b00;
  logic [8:0] trig_pos = '0;
  logic [3:0] dec_pwr = '0;
  logic       dump_start = 1'b0;
  logic [1:0] dump_ch = '0;
  logic       dump_rdy = 1'b0;
  logic       we, re, dump_vld, armed, capture_done, dump_finished;
  logic [8:0] addr, trace_end;
  logic [1:0] ch_sel;

  int         check_count = 0;
  int         pass_count = 0;
  int         wr_cnt = 0;
  logic [8:0] exp_addr = '0;
  logic [8:0] exp_rd;
  int         guard, gap, rd_seen, vld_seen;
  logic       prev_re;

  capture_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cap_start     (cap_start),
    .smpl_en       (smpl_en),
    .trigger       (trigger),
    .trig_type     (trig_type),
    .trig_pos      (trig_pos),
    .dec_pwr       (dec_pwr),
    .dump_start    (dump_start),
    .dump_ch       (dump_ch),
    .dump_rdy      (dump_rdy),
    .we            (we),
    .re            (re),
    .addr          (addr),
    .ch_sel        (ch_sel),
    .dump_vld      (dump_vld),
    .armed         (armed),
    .capture_done  (capture_done),
    .dump_finished (dump_finished),
    .trace_end     (trace_end)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    else
      pass_count++;
  endtask

  // Advance one cycle and check every write against the running address model.
  task automatic tick();
    @(posedge clk);
    #1;
    if (we) begin
      checkOutput("wr_addr", addr, exp_addr);
      checkOutput("we_re_excl", re, 0);
      exp_addr = exp_addr + 9'd1;
      wr_cnt++;
    end
  endtask

  task automatic checkAllZero(input string pfx);
    checkOutput({pfx, "_we"}, we, 0);
    checkOutput({pfx, "_re"}, re, 0);
    checkOutput({pfx, "_addr"}, addr, 0);
    checkOutput({pfx, "_ch_sel"}, ch_sel, 0);
    checkOutput({pfx, "_dump_vld"}, dump_vld, 0);
    checkOutput({pfx, "_armed"}, armed, 0);
    checkOutput({pfx, "_capture_done"}, capture_done, 0);
    checkOutput({pfx, "_dump_finished"}, dump_finished, 0);
    checkOutput({pfx, "_trace_end"}, trace_end, 0);
  endtask

  task automatic waitWrites(input int target);
    guard = 0;
    while (wr_cnt < target && guard < 5000) begin
      tick();
      guard++;
    end
  endtask

  task automatic startCapture();
    wr_cnt = 0;
    exp_addr = '0;
    cap_start = 1'b1;
    tick();
    cap_start = 1'b0;
  endtask

  initial begin
    #3 rst_n = 1'b0;
    tick();
    tick();
    checkAllZero("reset");
    rst_n = 1'b1;
    smpl_en = 1'b1;

    // Starts that must be ignored: capture with trigger off, dump outside DONE.
    trig_type = 2'b00;
    cap_start = 1'b1;
    dump_start = 1'b1;
    tick();
    cap_start = 1'b0;
    dump_start = 1'b0;
    repeat (10) tick();
    checkOutput("off_no_writes", wr_cnt, 0);
    checkOutput("off_armed", armed, 0);
    checkOutput("idle_dump_ignored", capture_done, 0);

    // Normal trigger, trig_pos=100, decimate by 4.
    trig_type = 2'b01;
    trig_pos = 9'd100;
    dec_pwr = 4'd2;
    startCapture();
    gap = 0;
    do begin tick(); gap++; end while (!we && gap < 20);
    checkOutput("dec_first_gap", gap, 4);
    for (int i = 0; i < 3; i++) begin
      gap = 0;
      do begin tick(); gap++; end while (!we && gap < 20);
      checkOutput("dec_gap", gap, 4);
    end
    waitWrites(200);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    checkOutput("pre_trig_ignored", armed, 0);
    waitWrites(412);
    checkOutput("wr_412", wr_cnt, 412);
    checkOutput("armed_at_412w", armed, 0);
    tick();
    checkOutput("armed_after_412w", armed, 1);
    waitWrites(422);
    checkOutput("armed_hold", armed, 1);
    checkOutput("armed_not_done", capture_done, 0);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    guard = 0;
    while (!capture_done && guard < 2000) begin
      tick();
      guard++;
    end
    checkOutput("done_reached", capture_done, 1);
    checkOutput("post_writes", wr_cnt - 422, 100);
    checkOutput("trace_end_norm", trace_end, 9);
    checkOutput("done_armed", armed, 0);
    cap_start = 1'b1;
    tick();
    cap_start = 1'b0;
    repeat (12) tick();
    checkOutput("no_wr_in_done", wr_cnt, 522);
    checkOutput("done_hold", capture_done, 1);

    // Dump channel 2 with dump_rdy toggling; oldest sample is at address 10.
    dump_ch = 2'd2;
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    checkOutput("dump_ch_sel", ch_sel, 2);
    exp_rd = 9'd10;
    rd_seen = 0;
    vld_seen = 0;
    guard = 0;
    while (!dump_finished && guard < 4000) begin
      dump_rdy = guard[0];
      #1;
      if (re) begin
        checkOutput("rd_addr", addr, exp_rd);
        exp_rd = exp_rd + 9'd1;
        rd_seen++;
      end
      prev_re = re;
      tick();
      checkOutput("vld_latency", dump_vld, prev_re);
      if (dump_vld) begin
        vld_seen++;
        checkOutput("vld_ch_sel", ch_sel, 2);
      end
      guard++;
    end
    dump_rdy = 1'b0;
    checkOutput("dump_finished_pulse", dump_finished, 1);
    checkOutput("rd_count", rd_seen, 512);
    checkOutput("vld_count", vld_seen, 512);
    checkOutput("finish_capture_done", capture_done, 0);
    tick();
    checkOutput("dump_finished_1cyc", dump_finished, 0);

    // Autoroll with trig_pos=0: DONE straight after one ARMED cycle.
    trig_type = 2'b10;
    trig_pos = 9'd0;
    dec_pwr = 4'd1;
    startCapture();
    waitWrites(512);
    checkOutput("auto_pre_armed", armed, 0);
    tick();
    checkOutput("auto_armed", armed, 1);
    tick();
    checkOutput("auto_done", capture_done, 1);
    checkOutput("auto_armed_clr", armed, 0);
    checkOutput("auto_trace_end", trace_end, 511);
    checkOutput("auto_writes", wr_cnt, 512);

    // Reset in the middle of a dump.
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    dump_rdy = 1'b1;
    repeat (20) tick();
    checkOutput("dump_running_re", re, 1);
    rst_n = 1'b0;
    #1;
    dump_rdy = 1'b0;
    #1;
    checkAllZero("rst_dump");
    tick();
    rst_n = 1'b1;

    // Trigger switched off mid-POST aborts back to IDLE.
    trig_type = 2'b01;
    trig_pos = 9'd100;
    dec_pwr = 4'd0;
    startCapture();
    guard = 0;
    while (!armed && guard < 2000) begin
      tick();
      guard++;
    end
    checkOutput("abort_armed", armed, 1);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    repeat (20) tick();
    checkOutput("abort_in_post", armed, 1);
    checkOutput("abort_not_done", capture_done, 0);
    trig_type = 2'b00;
    tick();
    checkAllZero("abort");
    repeat (5) tick();
    checkOutput("abort_stays_idle", we, 0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
